// File: rtl/nios_sd_loader_pio_pkg.sv
// Shared constants and types for the Nios SD-loader output PIO:
// register map, CTRL/STATUS bit positions and strobe FSM states.
package nios_sd_loader_pio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_OUTSET = 2'd2;
    localparam logic [1:0] ADDR_OUTCLR = 2'd3;

    localparam int CTRL_TRIG    = 0;
    localparam int CTRL_OVR_CLR = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_OVR  = 1;

    typedef enum logic {
        IDLE,
        PULSE
    } strobe_state_e;

endpackage

// File: rtl/nios_sd_loader_cpu_out_pio_if.sv
// Avalon-MM slave bus bundle for the output PIO (32-bit data, word addressed).
interface nios_sd_loader_cpu_out_pio_if;

    logic        chipselect;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        read_n;
    logic [31:0] readdata;

    modport master (
        output chipselect, address, write_n, writedata, read_n,
        input  readdata
    );

    modport slave (
        input  chipselect, address, write_n, writedata, read_n,
        output readdata
    );

endinterface

// File: rtl/nios_sd_loader_strobe_gen.sv
// Counted strobe pulse generator: a trigger yields exactly STROBE_LEN high
// cycles; triggers arriving while a pulse is running only set overrun.
module nios_sd_loader_strobe_gen
    import nios_sd_loader_pio_pkg::*;
#(
    parameter int STROBE_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    input  logic ovr_clr,
    output logic strobe,
    output logic busy,
    output logic overrun
);

    localparam int CW = $clog2(STROBE_LEN + 1);
    localparam logic [CW-1:0] LOAD = CW'(STROBE_LEN);

    strobe_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ovr_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            overrun <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ovr_nxt   = overrun;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nxt = PULSE;
                    cnt_nxt   = LOAD;
                end
            end
            PULSE: begin
                // The last pulse cycle still counts as busy for an incoming trigger.
                if (cnt <= CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (trig && state == PULSE)
            ovr_nxt = 1'b1;
        else if (ovr_clr)
            ovr_nxt = 1'b0;
    end

    assign strobe = (state == PULSE);
    assign busy   = (state == PULSE);

endmodule

// File: rtl/nios_sd_loader_cpu_out_pio.sv
// CPU output PIO: DATA/OUTSET/OUTCLEAR access to out_port plus a CTRL/STATUS
// register driving the counted strobe generator. Read latency is one cycle.
module nios_sd_loader_cpu_out_pio
    import nios_sd_loader_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    STROBE_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    nios_sd_loader_cpu_out_pio_if.slave   bus,
    output logic [DATA_WIDTH-1:0]         out_port,
    output logic                          strobe
);

    logic                  wr, rd;
    logic                  trig, ovr_clr;
    logic                  busy, overrun;
    logic [DATA_WIDTH-1:0] wdata;
    logic [31:0]           rd_mux;
    logic                  unused_wdata;

    assign wr    = bus.chipselect & ~bus.write_n;
    assign rd    = bus.chipselect & ~bus.read_n;
    assign wdata = bus.writedata[DATA_WIDTH-1:0];

    // Bits above DATA_WIDTH are don't-care on writes.
    assign unused_wdata = ^bus.writedata;

    assign trig    = wr && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_TRIG];
    assign ovr_clr = wr && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_OVR_CLR];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= RESET_VALUE;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:   out_port <= wdata;
                ADDR_OUTSET: out_port <= out_port | wdata;
                ADDR_OUTCLR: out_port <= out_port & ~wdata;
                default:     out_port <= out_port;
            endcase
        end
    end

    // Mux sees pre-write state, so a simultaneous rd+wr returns the old value.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux = 32'(out_port);
            ADDR_CTRL: begin
                rd_mux[ST_BUSY] = busy;
                rd_mux[ST_OVR]  = overrun;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            bus.readdata <= '0;
        else if (rd)
            bus.readdata <= rd_mux;
    end

    nios_sd_loader_strobe_gen #(
        .STROBE_LEN(STROBE_LEN)
    ) u_strobe (
        .clk     (clk),
        .reset   (reset),
        .trig    (trig),
        .ovr_clr (ovr_clr),
        .strobe  (strobe),
        .busy    (busy),
        .overrun (overrun)
    );

endmodule
